// File: rtl/output_router_block.sv
// output_router_block: egress side of a NoC router. Buffers one flit stream
// in a small FIFO, XY-decodes the head flit, and steers it into one of five
// one-entry holding registers (east, west, north, south, local core). Each
// port handshakes on its own, so a stalled neighbour only blocks flits that
// queue behind it. Per-port delivered-flit counters are exported packed.
module output_router_block #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2,
  parameter int MY_X  = 1,
  parameter int MY_Y  = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  // flit stream from the router core
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  // east neighbour
  output logic [WIDTH-1:0]   out1_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  // west neighbour
  output logic [WIDTH-1:0]   out2_data,
  output logic               out2_valid,
  input  logic               out2_ready,
  // north neighbour
  output logic [WIDTH-1:0]   out3_data,
  output logic               out3_valid,
  input  logic               out3_ready,
  // south neighbour
  output logic [WIDTH-1:0]   out4_data,
  output logic               out4_valid,
  input  logic               out4_ready,
  // local core
  output logic [WIDTH-1:0]   core_data,
  output logic               core_valid,
  input  logic               core_ready,
  // delivered-flit counters {core, out4, out3, out2, out1}
  output logic [5*CNT_W-1:0] fwd_count
);

  localparam int NPORT  = 5;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(DEPTH);
  localparam logic [1:0]        MY_X_C  = MY_X[1:0];
  localparam logic [1:0]        MY_Y_C  = MY_Y[1:0];

  // Port index doubles as the bit position in the per-port vectors below.
  typedef enum logic [2:0] {
    PORT_EAST  = 3'd0,
    PORT_WEST  = 3'd1,
    PORT_NORTH = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_CORE  = 3'd4
  } port_e;

  // ---------------------------------------------------------------------
  // Input FIFO state
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [1:0]       dest_x;
  logic [1:0]       dest_y;
  port_e            route;

  // ---------------------------------------------------------------------
  // Per-port holding registers and counters
  // ---------------------------------------------------------------------
  logic [NPORT-1:0] hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q [NPORT];
  logic [WIDTH-1:0] hold_data_d [NPORT];
  logic [CNT_W-1:0] cnt_q [NPORT];
  logic [CNT_W-1:0] cnt_d [NPORT];

  logic [NPORT-1:0] port_ready;
  logic [NPORT-1:0] drain;
  logic [NPORT-1:0] pop_sel;

  assign port_ready = {core_ready, out4_ready, out3_ready, out2_ready, out1_ready};

  // Acceptance looks only at the registered fill level, so a full FIFO
  // refuses input for a cycle even while it is popping.
  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid & in_ready;

  assign head   = mem_q[rd_ptr_q];
  assign dest_x = head[WIDTH-1 -: 2];
  assign dest_y = head[WIDTH-3 -: 2];

  // XY route decode on the FIFO head: resolve X first, then Y, else local.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    route = PORT_CORE;
    if (dest_x > MY_X_C) begin
      route = PORT_EAST;
    end else if (dest_x < MY_X_C) begin
      route = PORT_WEST;
    end else if (dest_y > MY_Y_C) begin
      route = PORT_NORTH;
    end else if (dest_y < MY_Y_C) begin
      route = PORT_SOUTH;
    end
  end

  // A register drains when its neighbour takes the flit this edge; the head
  // may move into its target if that target is empty or draining now.
  assign drain   = hold_valid_q & port_ready;
  assign pop     = (count_q != '0) && (!hold_valid_q[route] || drain[route]);
  assign pop_sel = pop ? (NPORT'(1) << route) : '0;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Holding-register and counter next-state; a refill on the drain edge
  // overrides the clear so valid stays high with the new flit.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      hold_valid_d[i] = hold_valid_q[i];
      hold_data_d[i]  = hold_data_q[i];
      cnt_d[i]        = cnt_q[i];
      if (drain[i]) begin
        hold_valid_d[i] = 1'b0;
        cnt_d[i]        = cnt_q[i] + CNT_W'(1);
      end
      if (pop_sel[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = head;
      end
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the cleared count and pointers make stale contents unreachable.
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control state, holding registers and counters; reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_valid_q <= '0;
      for (int i = 0; i < NPORT; i++) begin
        hold_data_q[i] <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples the pre-edge values.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < NPORT; i++) begin
        hold_data_q[i] <= hold_data_d[i];
        cnt_q[i]       <= cnt_d[i];
      end
    end
  end

  // Port outputs come straight from the holding registers.
  assign out1_data  = hold_data_q[PORT_EAST];
  assign out1_valid = hold_valid_q[PORT_EAST];
  assign out2_data  = hold_data_q[PORT_WEST];
  assign out2_valid = hold_valid_q[PORT_WEST];
  assign out3_data  = hold_data_q[PORT_NORTH];
  assign out3_valid = hold_valid_q[PORT_NORTH];
  assign out4_data  = hold_data_q[PORT_SOUTH];
  assign out4_valid = hold_valid_q[PORT_SOUTH];
  assign core_data  = hold_data_q[PORT_CORE];
  assign core_valid = hold_valid_q[PORT_CORE];

  // Pack counters with out1 in the least-significant slot.
  for (genvar g = 0; g < NPORT; g++) begin : g_cnt
    assign fwd_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_output_router_block.sv
// Scoreboard bench for output_router_block. Accepted flits are routed by a
// plain XY reference and queued per port; a negedge monitor pops and compares
// every delivered flit, checks hold stability under stall and tracks the
// expected per-port counters (CNT_W=4 so wrap is exercised throughout).
module tb_output_router_block;

  localparam int W    = 11;
  localparam int D    = 2;
  localparam int CW   = 4;
  localparam int MYX  = 1;
  localparam int MYY  = 1;
  localparam int NP   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  wire           in_ready;
  logic [NP-1:0] rdy;
  wire [W-1:0]   out1_data, out2_data, out3_data, out4_data, core_data;
  wire           out1_valid, out2_valid, out3_valid, out4_valid, core_valid;
  wire [NP*CW-1:0] fwd_count;

  output_router_block #(
    .WIDTH(W), .DEPTH(D), .MY_X(MYX), .MY_Y(MYY), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(rdy[0]),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(rdy[1]),
    .out3_data(out3_data), .out3_valid(out3_valid), .out3_ready(rdy[2]),
    .out4_data(out4_data), .out4_valid(out4_valid), .out4_ready(rdy[3]),
    .core_data(core_data), .core_valid(core_valid), .core_ready(rdy[4]),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [NP-1:0] vld = {core_valid, out4_valid, out3_valid, out2_valid, out1_valid};
  wire [W-1:0]  dat [NP];
  assign dat[0] = out1_data;
  assign dat[1] = out2_data;
  assign dat[2] = out3_data;
  assign dat[3] = out4_data;
  assign dat[4] = core_data;

  string pn [NP] = '{"out1", "out2", "out3", "out4", "core"};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s act=%s (cycle %0d)", name, what, cyc);
  endtask

  // Reference XY routing: 0=east,1=west,2=north,3=south,4=core.
  function automatic int route_of(input logic [W-1:0] f);
    int x = int'(f[10:9]);
    int y = int'(f[8:7]);
    if (x > MYX) return 0;
    if (x < MYX) return 1;
    if (y > MYY) return 2;
    if (y < MYY) return 3;
    return 4;
  endfunction

  // ---------------------------------------------------------------------
  // Ready driver: 0 all ready, 1 random, 2 core toggles, 3 manual mask
  // ---------------------------------------------------------------------
  int            rdy_mode   = 0;
  logic [NP-1:0] manual_rdy = '1;

  initial begin
    rdy = '1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy = '1;
        1:       rdy = NP'($urandom);
        2:       rdy = {~rdy[4], 4'hF};
        default: rdy = manual_rdy;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard state (written only by the monitor)
  // ---------------------------------------------------------------------
  logic [W-1:0] exp_q [NP][$];
  int           model_cnt [NP];
  bit           stall [NP];
  logic [W-1:0] held  [NP];
  int           core_cyc_q [$];

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NP; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Monitor: inputs are stable at the negedge, so whatever handshakes are
  // visible here complete on the following rising edge.
  initial begin
    for (int i = 0; i < NP; i++) begin
      model_cnt[i] = 0;
      stall[i]     = 1'b0;
      held[i]      = '0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < NP; i++) begin
          exp_q[i].delete();
          model_cnt[i] = 0;
          stall[i]     = 1'b0;
        end
        continue;
      end
      for (int i = 0; i < NP; i++) begin
        check($sformatf("%s_count", pn[i]), 32'(fwd_count[i*CW +: CW]), 32'(model_cnt[i]));
        if (stall[i]) begin
          check($sformatf("%s_hold_valid", pn[i]), 32'(vld[i]), 32'd1);
          check($sformatf("%s_hold_data", pn[i]), 32'(dat[i]), 32'(held[i]));
        end
        if (vld[i] && rdy[i]) begin
          if (exp_q[i].size() == 0) begin
            fail($sformatf("%s_unexpected", pn[i]), $sformatf("flit 0x%0h exp=none", dat[i]));
          end else begin
            check($sformatf("%s_data", pn[i]), 32'(dat[i]), 32'(exp_q[i].pop_front()));
          end
          model_cnt[i] = (model_cnt[i] + 1) % (1 << CW);
          if (i == 4) core_cyc_q.push_back(cyc);
        end
        stall[i] = vld[i] && !rdy[i];
        held[i]  = dat[i];
      end
      if (in_valid && in_ready) begin
        exp_q[route_of(in_data)].push_back(in_data);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // ---------------------------------------------------------------------
  task automatic send(input logic [W-1:0] f, input int gap);
    bit ok = 1'b0;
    in_data  = f;
    in_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("send_accept", "timeout exp=accept");
    @(posedge clk);
    #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (pending() == 0 && vld == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail(name, $sformatf("pending=%0d exp=0", pending()));
    @(posedge clk);
    #1;
  endtask

  // Single flit with latency check: invalid right after acceptance, valid one edge later.
  task automatic single(input logic [W-1:0] f, input int p);
    send(f, 0);
    idle();
    check($sformatf("%s_lat_early", pn[p]), 32'(vld[p]), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("%s_lat_valid", pn[p]), 32'(vld[p]), 32'd1);
    check($sformatf("%s_lat_data", pn[p]), 32'(dat[p]), 32'(f));
    wait_drain("single_drain");
  endtask

  task automatic set_manual(input logic [NP-1:0] m);
    manual_rdy = m;
    rdy_mode   = 3;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset state
    @(negedge clk);
    check("rst_valids", 32'(vld), 32'd0);
    check("rst_count", 32'(fwd_count), 32'd0);
    check("rst_data", 32'({out1_data, out2_data}), 32'd0);
    check("rst_data_b", 32'({out3_data, out4_data}), 32'd0);
    check("rst_data_core", 32'(core_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single flits to every port
    single(11'h685, 0);
    single(11'h101, 1);
    single(11'h3FF, 2);
    single(11'h203, 3);
    single(11'h2AA, 4);
    check("single_counts", 32'(fwd_count), 32'h11111);

    // Backpressure and head-of-line blocking
    set_manual(5'b11110);
    send(11'h685, 0);
    send(11'h686, 0);
    send(11'h2AA, 0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_core_hol", 32'(core_valid), 32'd0);
    check("bp_out1_valid", 32'(out1_valid), 32'd1);
    check("bp_out1_data", 32'(out1_data), 32'h685);
    @(posedge clk);
    #1;
    manual_rdy = 5'b11111;
    wait_drain("bp_drain");

    // Streaming: 20 back-to-back core flits, one delivery per cycle
    rdy_mode = 0;
    n0 = core_cyc_q.size();
    for (int i = 0; i < 20; i++) send(11'h280 + 11'(i), 0);
    idle();
    wait_drain("stream_drain");
    check("stream_n", 32'(core_cyc_q.size() - n0), 32'd20);
    if (core_cyc_q.size() - n0 == 20)
      check("stream_span", 32'(core_cyc_q[n0 + 19] - core_cyc_q[n0]), 32'd19);

    // Stall/refill with core_ready toggling
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) send(11'h2A0 + 11'(i), 0);
    idle();
    wait_drain("toggle_drain");
    rdy_mode = 0;

    // Reset mid-operation: out3 held, FIFO full behind it
    set_manual(5'b11011);
    send(11'h3FF, 0);
    send(11'h3FE, 0);
    send(11'h3FD, 0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_out3_valid", 32'(out3_valid), 32'd1);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valids", 32'(vld), 32'd0);
    check("mid_rst_out3_data", 32'(out3_data), 32'd0);
    check("mid_rst_count", 32'(fwd_count), 32'd0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_in_ready_rel", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    single(11'h203, 3);

    // Counter wrap: 17 flits to out2 on a 4-bit counter
    for (int i = 0; i < 17; i++) send(11'h100 + 11'(i), 0);
    idle();
    wait_drain("wrap_drain");
    check("wrap_out2", 32'(fwd_count[2*CW-1:CW]), 32'd1);

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    idle();
    rdy_mode = 0;
    wait_drain("rand_drain");
    check("final_pending", 32'(pending()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_router_block.md
Name: output_router_block

Overview:
- Egress counterpart of the NoC input arbitration tree. It accepts one 11-bit flit stream from the router core, buffers it in a small FIFO, and decodes the destination with XY routing.
- Each flit is steered to exactly one of four neighbour output ports (out1..out4) or to the local core port.
- Fully synchronous: single clock, valid/ready handshakes on every port, per-port registered outputs so a stalled port does not corrupt the others.

Parameters:
- WIDTH, 11, flit width; [10:9]=dest_x, [8:7]=dest_y, [6:0]=payload.
- DEPTH, 2, input FIFO entries (power of 2, >=2).
- MY_X, 1, this router's X coordinate (2 bits).
- MY_Y, 1, this router's Y coordinate (2 bits).
- CNT_W, 16, width of per-port forwarded-flit counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  flit from router core.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept.
- outN_data  output  WIDTH  (N=1..4; 1=east, 2=west, 3=north, 4=south) flit to neighbour N.
- outN_valid  output  1  outN_data valid.
- outN_ready  input  1  neighbour N accepts.
- core_data  output  WIDTH  flit to local core.
- core_valid  output  1  core_data valid.
- core_ready  input  1  core accepts.
- fwd_count  output  5*CNT_W  packed counters {core,out4,out3,out2,out1}, flits delivered per port.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, all *_valid=0, all *_data=0, fwd_count=0. in_ready=1 once reset deasserts. Reset mid-transfer discards all buffered and held flits; no partial delivery.
- Input handshake: transfer on a rising edge with in_valid & in_ready. in_ready = (count < DEPTH), registered-count based, with no same-cycle pop bypass, so a full FIFO blocks input for at least one cycle even if popping.
- Route decode is combinational on the FIFO head:
  - dest_x > MY_X -> out1; dest_x < MY_X -> out2.
  - Otherwise dest_y > MY_Y -> out3; dest_y < MY_Y -> out4.
  - Otherwise -> core.
- Each of the 5 ports has a one-entry holding register (valid + data), FULL when valid=1.
- Pop: on an edge where the FIFO is non-empty and the target holding register is empty or draining that same edge (valid & ready), pop the head into it. At most one pop per edge.
- Head-of-line blocking: if the target register is full and not draining, the head waits; later flits to other ports wait behind it. Order is preserved globally.
- Output handshake: port transfer on an edge with valid & ready. valid stays high and data stable until accepted. A drain and a refill of the same register on one edge leave valid=1 with the new data.
- Latency: a flit accepted at edge k into an empty FIFO with a free target is valid on its port after edge k+1 (2-edge minimum). Sustained throughput is 1 flit/cycle while no port stalls.
- Simultaneous push and pop on one edge: count unchanged; pointers wrap modulo DEPTH.
- Counter: the per-port counter increments on each output transfer and wraps at 2^CNT_W-1 -> 0.
- No flit is ever dropped or duplicated; *_valid never deasserts without a handshake except on reset.

Test Plan:
- Reset then single flits (MY_X=MY_Y=1, all readies=1): 0x685 -> out1, 0x101 -> out2, 0x3FF -> out3, 0x203 -> out4, 0x2AA -> core. Each is seen exactly once, 2 edges after acceptance, with data unchanged; fwd_count = 1 per port.
- Backpressure: out1_ready=0, send 0x685, 0x686, 0x2AA. 0x685 is held on out1; 0x686 and 0x2AA fill the FIFO; in_ready=0; core_valid stays 0 (HOL). Raise out1_ready: delivery order is 0x685, 0x686, then 0x2AA on core.
- Streaming: 20 back-to-back core flits 0x280..0x293 with core_ready=1. One flit per cycle after a 2-edge fill, in order; core counter = 20.
- Stall/refill: core_ready toggles 1,0,1,0 during a stream. core_data stays stable while ready=0; no loss or duplication.
- Reset mid-operation: FIFO holding 2 flits and out3_valid=1, assert reset. All valids go 0 immediately (async); after release in_ready=1 and count=0; a new flit 0x203 routes to out4 normally.
- Counter wrap: CNT_W=4, 17 flits to out2. out2 counter reads 1.
